// File: rtl/game_sfx_mixer.sv
// game_sfx_mixer: square-wave sample source (crash tone, score chirp, music)
// Ports: clk, reset, life, score, game_over, music_bit, mute, write_ready -> write, writedata_left/right
module game_sfx_mixer #(
  parameter logic [23:0] AMPLITUDE  = 24'd2000000,
  parameter int          CRASH_HALF = 120,
  parameter int          CRASH_LEN  = 9600,
  parameter int          SCORE_HALF = 30,
  parameter int          SCORE_LEN  = 2400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  life,
  input  logic [7:0]  score,
  input  logic        game_over,
  input  logic        music_bit,
  input  logic        mute,
  input  logic        write_ready,
  output logic        write,
  output logic [23:0] writedata_left,
  output logic [23:0] writedata_right
);

  localparam int CW = 16;
  localparam logic signed [23:0] AMP = AMPLITUDE;
  localparam logic signed [23:0] MUS = AMP >>> 1;

  typedef enum logic [1:0] {
    FX_IDLE,
    FX_SCORE,
    FX_CRASH
  } fx_t;

  typedef enum logic [1:0] {
    HS_WAIT,
    HS_ISSUE,
    HS_GAP
  } hs_t;

  fx_t fx_q, fx_d;
  hs_t hs_q, hs_d;

  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic [2:0]    prev_life;
  logic [7:0]    prev_score;
  logic [23:0]   data_q, data_d;
  logic [23:0]   sample;
  logic          crash_trig, score_trig;
  logic          len_last, half_last;

  assign crash_trig = (life < prev_life);
  assign score_trig = (score > prev_score);

  assign write           = (hs_q == HS_ISSUE);
  assign writedata_left  = data_q;
  assign writedata_right = data_q;

  always_comb begin
    len_last  = 1'b0;
    half_last = 1'b0;
    if (fx_q == FX_CRASH) begin
      len_last  = (len_q == CW'(CRASH_LEN - 1));
      half_last = (half_q == CW'(CRASH_HALF - 1));
    end else begin
      len_last  = (len_q == CW'(SCORE_LEN - 1));
      half_last = (half_q == CW'(SCORE_HALF - 1));
    end
  end

  // Crash outranks score; counters only move on an actual push.
  always_comb begin
    fx_d    = fx_q;
    len_d   = len_q;
    half_d  = half_q;
    phase_d = phase_q;
    priority case (1'b1)
      crash_trig: begin
        fx_d    = FX_CRASH;
        len_d   = '0;
        half_d  = '0;
        phase_d = 1'b0;
      end
      score_trig && (fx_q != FX_CRASH): begin
        fx_d    = FX_SCORE;
        len_d   = '0;
        half_d  = '0;
        phase_d = 1'b0;
      end
      write && (fx_q != FX_IDLE): begin
        if (len_last) begin
          fx_d    = FX_IDLE;
          len_d   = '0;
          half_d  = '0;
          phase_d = 1'b0;
        end else begin
          len_d = len_q + 1'b1;
          if (half_last) begin
            half_d  = '0;
            phase_d = ~phase_q;
          end else begin
            half_d = half_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sample = '0;
    if (mute) begin
      sample = '0;
    end else if (fx_q != FX_IDLE) begin
      sample = phase_q ? AMP : -AMP;
    end else if (!game_over) begin
      sample = music_bit ? MUS : -MUS;
    end
  end

  // The GAP cycle lets the CODEC refresh write_ready after a push.
  always_comb begin
    hs_d   = hs_q;
    data_d = data_q;
    unique case (hs_q)
      HS_WAIT: begin
        if (write_ready) begin
          data_d = sample;
          hs_d   = HS_ISSUE;
        end
      end
      HS_ISSUE: hs_d = HS_GAP;
      HS_GAP:   hs_d = HS_WAIT;
      default:  hs_d = HS_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fx_q       <= FX_IDLE;
      hs_q       <= HS_WAIT;
      len_q      <= '0;
      half_q     <= '0;
      phase_q    <= 1'b0;
      data_q     <= '0;
      prev_life  <= life;
      prev_score <= score;
    end else begin
      fx_q       <= fx_d;
      hs_q       <= hs_d;
      len_q      <= len_d;
      half_q     <= half_d;
      phase_q    <= phase_d;
      data_q     <= data_d;
      prev_life  <= life;
      prev_score <= score;
    end
  end

endmodule

// File: tb/tb_game_sfx_mixer.sv
// tb_game_sfx_mixer: vector table, directed effect sequences, random vs model
// Drives game_sfx_mixer and checks write / writedata_* every cycle
module tb_game_sfx_mixer;

  localparam logic [23:0] P  = 24'd2000000;
  localparam logic [23:0] N  = 24'hE17B80;
  localparam logic [23:0] MP = 24'd1000000;
  localparam logic [23:0] MN = 24'hF0BDC0;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  life;
  logic [7:0]  score;
  logic        game_over, music_bit, mute, write_ready;
  logic        write;
  logic [23:0] wl, wrr;

  always #5 clk = ~clk;

  game_sfx_mixer dut (
    .clk(clk), .reset(reset), .life(life), .score(score),
    .game_over(game_over), .music_bit(music_bit), .mute(mute),
    .write_ready(write_ready), .write(write),
    .writedata_left(wl), .writedata_right(wrr)
  );

  int total = 0;
  int bad = 0;
  logic [23:0] wq[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: effect = kind + count of effect samples pushed so far.
  int          m_kind, m_n, m_hs;
  logic [23:0] m_data;
  logic [2:0]  m_pl;
  logic [7:0]  m_ps;

  function automatic logic [23:0] m_sample();
    int half;
    if (mute) return 24'd0;
    if (m_kind != 0) begin
      half = (m_kind == 2) ? 120 : 30;
      return ((m_n / half) % 2 == 1) ? P : N;
    end
    if (!game_over) return music_bit ? MP : MN;
    return 24'd0;
  endfunction

  task automatic model_edge();
    logic [23:0] s;
    bit wnow;
    int len;
    if (reset) begin
      m_kind = 0; m_n = 0; m_hs = 0; m_data = 0;
    end else begin
      wnow = (m_hs == 1);
      s = m_sample();
      if (life < m_pl) begin
        m_kind = 2; m_n = 0;
      end else if (score > m_ps && m_kind != 2) begin
        m_kind = 1; m_n = 0;
      end else if (wnow && m_kind != 0) begin
        len = (m_kind == 2) ? 9600 : 2400;
        m_n++;
        if (m_n == len) begin
          m_kind = 0; m_n = 0;
        end
      end
      if (m_hs == 0 && write_ready) begin
        m_data = s; m_hs = 1;
      end else if (m_hs == 1) m_hs = 2;
      else if (m_hs == 2) m_hs = 0;
    end
    m_pl = life;
    m_ps = score;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cyc", {15'd0, write, wl, wrr}, {15'd0, m_hs == 1, m_data, m_data});
    if (write) wq.push_back(wl);
  endtask

  task automatic collect(int n);
    int budget = n * 3 + 20;
    while (wq.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (wq.size() < n) begin
      chk("timeout", 64'(wq.size()), 64'(n));
      while (wq.size() < n) wq.push_back('x);
    end
  endtask

  typedef struct {
    logic rst, wr, mb, mu, go;
    logic ew;
    logic [23:0] ed;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic rst, logic wr, logic mb, logic mu,
                              logic go, logic ew, logic [23:0] ed);
    vec_t v;
    v.rst = rst; v.wr = wr; v.mb = mb; v.mu = mu; v.go = go;
    v.ew = ew; v.ed = ed;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 1, 1, 0, 0, 0, 24'd0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 1, MP);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, MP);
    tbl[3]  = mk(0, 1, 1, 0, 0, 0, MP);
    tbl[4]  = mk(0, 1, 1, 0, 0, 1, MP);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, MP);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, MP);
    tbl[7]  = mk(0, 1, 0, 0, 0, 1, MN);
    tbl[8]  = mk(0, 1, 0, 1, 0, 0, MN);
    tbl[9]  = mk(0, 1, 0, 1, 0, 0, MN);
    tbl[10] = mk(0, 1, 0, 1, 0, 1, 24'd0);
    tbl[11] = mk(0, 0, 1, 0, 1, 0, 24'd0);
    tbl[12] = mk(0, 0, 1, 0, 1, 0, 24'd0);
    tbl[13] = mk(0, 0, 1, 0, 1, 0, 24'd0);
    tbl[14] = mk(0, 1, 1, 0, 1, 1, 24'd0);
    tbl[15] = mk(0, 1, 1, 0, 0, 0, 24'd0);
    tbl[16] = mk(0, 1, 1, 0, 0, 0, 24'd0);
    tbl[17] = mk(0, 1, 1, 0, 0, 1, MP);
    tbl[18] = mk(1, 1, 1, 0, 0, 0, 24'd0);
    tbl[19] = mk(0, 0, 1, 0, 0, 0, 24'd0);

    reset = 1; life = 3; score = 0; game_over = 0;
    music_bit = 1; mute = 0; write_ready = 1;
    m_kind = 0; m_n = 0; m_hs = 0; m_data = 0; m_pl = 3; m_ps = 0;

    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst; write_ready = tbl[i].wr;
      music_bit = tbl[i].mb; mute = tbl[i].mu; game_over = tbl[i].go;
      step();
      chk($sformatf("vec%0d", i), {15'd0, write, wl, wrr},
          {15'd0, tbl[i].ew, tbl[i].ed, tbl[i].ed});
    end

    // Score chirp 5 -> 6
    music_bit = 1; write_ready = 0; score = 5;
    repeat (3) step();
    score = 6; step();
    write_ready = 1; wq.delete();
    collect(2401);
    for (int i = 0; i < 60; i++)
      chk($sformatf("chirp%0d", i), 64'(wq[i]), 64'(i < 30 ? N : P));
    chk("chirp_last", 64'(wq[2399]), 64'(P));
    chk("chirp_end", 64'(wq[2400]), 64'(MP));

    // Crash preempts a running chirp; score during crash is dropped
    write_ready = 0; repeat (3) step();
    score = 7; step();
    write_ready = 1; wq.delete(); collect(100);
    write_ready = 0; repeat (3) step();
    life = 2; step();
    write_ready = 1; wq.delete(); collect(200);
    score = 8; collect(9601);
    chk("crash0", 64'(wq[0]), 64'(N));
    chk("crash119", 64'(wq[119]), 64'(N));
    chk("crash120", 64'(wq[120]), 64'(P));
    chk("crash239", 64'(wq[239]), 64'(P));
    chk("crash240", 64'(wq[240]), 64'(N));
    chk("crash_last", 64'(wq[9599]), 64'(P));
    chk("crash_end", 64'(wq[9600]), 64'(MP));

    // Simultaneous crash + score
    write_ready = 0; repeat (3) step();
    life = 1; score = 9; step();
    write_ready = 1; wq.delete(); collect(121);
    chk("sim0", 64'(wq[0]), 64'(N));
    chk("sim30", 64'(wq[30]), 64'(N));
    chk("sim119", 64'(wq[119]), 64'(N));
    chk("sim120", 64'(wq[120]), 64'(P));

    // Reset while a push is being issued, mid-crash
    for (int i = 0; i < 6 && !write; i++) step();
    reset = 1; step();
    chk("rst_issue", {39'd0, write, wl}, 64'd0);
    reset = 0;

    // Muted chirp still expires on schedule
    write_ready = 0; repeat (3) step();
    score = 10; step();
    mute = 1; write_ready = 1; wq.delete(); collect(2400);
    begin
      int nz = 0;
      foreach (wq[i]) if (wq[i] !== 24'd0) nz++;
      chk("mute_zero", 64'(nz), 64'd0);
    end
    mute = 0; wq.delete(); collect(1);
    chk("mute_expired", 64'(wq[0]), 64'(MP));

    // Stall: no writes, no counter movement
    write_ready = 0; step();
    score = 11; step();
    wq.delete(); repeat (50) step();
    chk("stall_writes", 64'(wq.size()), 64'd0);
    write_ready = 1; collect(31);
    chk("stall29", 64'(wq[29]), 64'(N));
    chk("stall30", 64'(wq[30]), 64'(P));

    // Single-cycle write_ready pulse
    write_ready = 0; repeat (3) step();
    wq.delete();
    write_ready = 1; step();
    write_ready = 0; repeat (10) step();
    chk("pulse_one", 64'(wq.size()), 64'd1);

    // Random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(999) == 0);
      write_ready = ($urandom_range(3) != 0);
      music_bit   = $urandom_range(1);
      if ($urandom_range(63) == 0) mute = ~mute;
      if ($urandom_range(63) == 0) game_over = ~game_over;
      if ($urandom_range(199) == 0) life = 3'($urandom_range(7));
      if ($urandom_range(99) == 0) score = 8'($urandom_range(255));
      else if ($urandom_range(149) == 0) score = score + 8'd1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
